mem_access_ctrl: RTL and testbench

- Load/store sequencer between the RV32 core's memory stage and a single 32-bit word-addressed data bus.
- Decodes funct3 into byte lane selects and replicates store data across lanes.
- Extracts and sign/zero-extends load data, checks alignment, and stalls the core until the bus acknowledges.
- Generalises the core's byte zero-extension path to LB/LH/LW/LBU/LHU/SB/SH/SW, with a bus timeout.

---
 rtl/mem_access_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Load/store sequencer between the RV32 memory stage and a
//               32-bit word-addressed data bus. Decodes funct3 into byte lane
//               selects, replicates store data, extends load data, flags
//               misaligned/illegal accesses and aborts stalled bus cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_out,
    output logic        stall,
    output logic        done,
    output logic        access_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // Sequencer states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Last counter value before the access is abandoned
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT - 1);

    // Access size encoded in funct3[1:0]
    localparam logic [1:0] c_SZ_B = 2'b00;
    localparam logic [1:0] c_SZ_H = 2'b01;
    localparam logic [1:0] c_SZ_W = 2'b10;

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_done;
    logic        r_err;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_rdata;
    logic        r_is_load;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lo;

    logic        w_req;
    logic        w_illegal;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load;
    logic        w_stall;

    assign w_req = mem_read | mem_write;

    // Request legality: conflicting commands, reserved encodings, unsigned
    // stores and misaligned halfword/word addresses never reach the bus
    always_comb begin
        w_illegal = 1'b0;
        if (mem_read && mem_write) begin
            w_illegal = 1'b1;
        end
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
            w_illegal = 1'b1;
        end
        if (mem_write && funct3[2]) begin
            w_illegal = 1'b1;
        end
        if (funct3[1:0] == c_SZ_H && addr[0]) begin
            w_illegal = 1'b1;
        end
        if (funct3[1:0] == c_SZ_W && addr[1:0] != 2'b00) begin
            w_illegal = 1'b1;
        end
    end

    // Byte lane enables and lane-replicated store data for the request
    always_comb begin
        w_sel   = 4'b0000;
        w_wdata = wdata;
        case (funct3[1:0])
            c_SZ_B: begin
                w_sel   = 4'b0001 << addr[1:0];
                w_wdata = {4{wdata[7:0]}};
            end
            c_SZ_H: begin
                w_sel   = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{wdata[15:0]}};
            end
            c_SZ_W: begin
                w_sel   = 4'b1111;
                w_wdata = wdata;
            end
            default: begin
                w_sel   = 4'b0000;
                w_wdata = wdata;
            end
        endcase
    end

    // Load data: shift the addressed lane down, then sign/zero-extend
    always_comb begin
        w_lane = bus_rdata >> {r_lo, 3'b000};
        case (r_funct3)
            3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b100:  w_load = {24'd0, w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b101:  w_load = {16'd0, w_lane[15:0]};
            default: w_load = bus_rdata;
        endcase
    end

    // Stall: immediate in IDLE so the core freezes on the request cycle;
    // held low while reset is asserted so the core is released at once
    always_comb begin
        case (r_state)
            c_ST_IDLE: w_stall = nrst & w_req;
            c_ST_BUSY: w_stall = 1'b1;
            default:   w_stall = 1'b0;
        endcase
    end

    // Sequencer: accept/decode in IDLE, run the bus cycle in BUSY, pulse DONE
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 8'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_sel   <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_rdata     <= 32'd0;
            r_is_load   <= 1'b0;
            r_funct3    <= 3'd0;
            r_lo        <= 2'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_req) begin
                        if (w_illegal) begin
                            // Rejected without ever touching the bus
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= c_ST_BUSY;
                            r_cnt       <= 8'd0;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= {addr[31:2], 2'b00};
                            r_bus_sel   <= w_sel;
                            r_bus_wdata <= w_wdata;
                            r_is_load   <= mem_read;
                            r_funct3    <= funct3;
                            r_lo        <= addr[1:0];
                        end
                    end
                end
                c_ST_BUSY: begin
                    if (bus_ack) begin
                        // Acknowledge wins over a simultaneous timeout
                        r_state   <= c_ST_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b0;
                        if (r_is_load) begin
                            r_rdata <= w_load;
                        end
                    end else if (r_cnt == c_TO_LAST) begin
                        r_state   <= c_ST_DONE;
                        r_bus_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ST_DONE: begin
                    // Requests seen here belong to the next instruction
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_bus_req <= 1'b0;
                    r_done    <= 1'b0;
                    r_err     <= 1'b0;
                end
            endcase
        end
    end

    assign rdata_out  = r_rdata;
    assign stall      = w_stall;
    assign done       = r_done;
    assign access_err = r_err;
    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_sel    = r_bus_sel;
    assign bus_wdata  = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl with a
//               transaction-level expectation model and per-cycle compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata_out;
    logic        stall;
    logic        done;
    logic        access_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    // Expected outputs for the current cycle
    logic        e_stall = 1'b0;
    logic        e_req   = 1'b0;
    logic        e_done  = 1'b0;
    logic        e_err   = 1'b0;
    logic        e_we    = 1'b0;
    logic [31:0] e_addr  = 32'd0;
    logic [3:0]  e_sel   = 4'd0;
    logic [31:0] e_wdata = 32'd0;
    logic [31:0] e_rdata = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata_out  (rdata_out),
        .stall      (stall),
        .done       (done),
        .access_err (access_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_sel    (bus_sel),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic m_err(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = 1 << f3[1:0];
        if (rd && wr) return 1'b1;
        if (f3 == 3 || f3 >= 6) return 1'b1;
        if (wr && f3 >= 4) return 1'b1;
        if ((a % sz) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] sh;
        logic [31:0] v;
        sh = d >> (8 * (a % 4));
        if (f3[1:0] == 2'd0) begin
            v = sh & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (f3[1:0] == 2'd1) begin
            v = sh & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // ---------------- single compare process ----------------
    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(e_stall));
        chk("bus_req", 32'(bus_req), 32'(e_req));
        chk("done", 32'(done), 32'(e_done));
        if (e_done) chk("access_err", 32'(access_err), 32'(e_err));
        chk("rdata_out", rdata_out, e_rdata);
        if (e_req) begin
            chk("bus_we", 32'(bus_we), 32'(e_we));
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_sel", 32'(bus_sel), 32'(e_sel));
            chk("bus_wdata", bus_wdata, e_wdata);
        end
    end

    // Runs one access; ack arrives after wait_n empty BUSY cycles (>=TO: none)
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int wait_n);
        bit got;
        bit tmo;
        int k;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        e_stall = 1'b1; e_req = 1'b0; e_done = 1'b0; e_err = 1'b0;
        @(posedge clk); #1;
        if (m_err(rd, wr, f3, a)) begin
            mem_read = 1'b0; mem_write = 1'b0;
            e_stall = 1'b0; e_done = 1'b1; e_err = 1'b1;
        end else begin
            e_req = 1'b1; e_we = wr; e_addr = a & ~32'd3;
            e_sel = m_sel(f3, a); e_wdata = m_wdata(f3, wd);
            got = 1'b0; tmo = 1'b0; k = 0;
            while (!got && !tmo) begin
                bus_ack   = (k == wait_n);
                bus_rdata = bus_ack ? rdat : 32'hDEAD_BEEF;
                @(posedge clk); #1;
                if (k == wait_n) got = 1'b1;
                else if (k == TO - 1) tmo = 1'b1;
                k++;
            end
            bus_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            e_req = 1'b0; e_stall = 1'b0; e_done = 1'b1; e_err = tmo;
            if (got && rd) e_rdata = m_load(f3, a, rdat);
        end
        @(posedge clk); #1;
        e_done = 1'b0; e_err = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state observed by the compare process, then release mid-cycle
        #22 nrst = 1'b1;
        @(posedge clk); #1;

        // LB / LBU from the top byte lane, ack on first BUSY cycle
        access(1, 0, 3'b000, 32'h0000_1003, 0, 32'h80AB_CD12, 0);
        chk("LB result", rdata_out, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h0000_1003, 0, 32'h80AB_CD12, 0);
        chk("LBU result", rdata_out, 32'h0000_0080);

        // SB with three wait cycles leaves the load result untouched
        access(0, 1, 3'b000, 32'h0000_2001, 32'h1234_56A5, 0, 3);
        chk("SB keeps rdata", rdata_out, 32'h0000_0080);

        // Halfword loads, signed and unsigned
        access(1, 0, 3'b001, 32'h0000_3002, 0, 32'h7FFF_8001, 1);
        chk("LH hi result", rdata_out, 32'h0000_7FFF);
        access(1, 0, 3'b101, 32'h0000_3000, 0, 32'h7FFF_8001, 0);
        chk("LHU lo result", rdata_out, 32'h0000_8001);
        access(1, 0, 3'b001, 32'h0000_3000, 0, 32'h7FFF_8001, 2);
        chk("LH lo result", rdata_out, 32'hFFFF_8001);

        // Rejected requests: misaligned, reserved, conflicting, unsigned store
        access(1, 0, 3'b001, 32'h0000_3001, 0, 0, 0);
        access(1, 0, 3'b010, 32'h0000_3006, 0, 0, 0);
        access(1, 0, 3'b011, 32'h0000_3000, 0, 0, 0);
        access(1, 1, 3'b010, 32'h0000_3000, 0, 0, 0);
        access(0, 1, 3'b100, 32'h0000_3000, 0, 0, 0);
        chk("errors keep rdata", rdata_out, 32'hFFFF_8001);

        // Halfword and word stores
        access(0, 1, 3'b001, 32'h0000_5002, 32'h0000_BEEF, 0, 1);
        access(0, 1, 3'b010, 32'h0000_5004, 32'h1122_3344, 0, 0);

        // Timeout on a word load, then a stray ack while idle
        access(1, 0, 3'b010, 32'h0000_4000, 0, 0, 99);
        chk("timeout keeps rdata", rdata_out, 32'hFFFF_8001);
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(posedge clk); #1;
        chk("late ack ignored", rdata_out, 32'hFFFF_8001);

        // Asynchronous reset in the middle of a store's bus cycle
        mem_write = 1'b1; funct3 = 3'b010; addr = 32'h0000_7000; wdata = 32'hA0A0_0B0B;
        e_stall = 1'b1;
        @(posedge clk); #1;
        e_req = 1'b1; e_we = 1'b1; e_addr = 32'h0000_7000; e_sel = 4'hF; e_wdata = 32'hA0A0_0B0B;
        @(negedge clk); #2;
        nrst = 1'b0;
        e_req = 1'b0; e_stall = 1'b0; e_rdata = 32'd0;
        #1;
        chk("async bus_req drop", 32'(bus_req), 32'd0);
        chk("async stall drop", 32'(stall), 32'd0);
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(posedge clk); #3;
        nrst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("no done after reset", 32'(done), 32'd0);

        access(1, 0, 3'b010, 32'h0000_6000, 0, 32'hCAFE_F00D, 2);
        chk("LW after reset", rdata_out, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
